// File: rtl/sp_ifft_cp.sv
// Post-IFFT amplitude restore (x22.5, saturate) with ping-pong
// symbol buffering and cyclic-prefix insertion.
module sp_ifft_cp #(
  parameter int N_FFT  = 64,
  parameter int N_CP   = 16,
  parameter int DW_IN  = 16,
  parameter int DW_OUT = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DW_IN-1:0]  di_re,
  input  logic signed [DW_IN-1:0]  di_im,
  input  logic                     di_vld,
  output logic                     di_rdy,
  output logic signed [DW_OUT-1:0] do_re,
  output logic signed [DW_OUT-1:0] do_im,
  output logic                     do_vld,
  output logic                     do_sof
);

  localparam int AW = $clog2(N_FFT);
  localparam int PW = DW_IN + 6;
  localparam int MW = 2 * DW_OUT;
  localparam logic [AW-1:0] CP0  = AW'(N_FFT - N_CP);
  localparam logic [AW-1:0] LAST = AW'(N_FFT - 1);
  localparam logic signed [PW-1:0] K45  = PW'(45);
  localparam logic signed [PW-1:0] SMAX =
    PW'((1 << (DW_OUT - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN =
    PW'(-(1 << (DW_OUT - 1)));

  typedef enum logic [1:0] {
    IDLE,
    CP,
    BODY
  } state_t;

  // x*45 then floor-halve gives the x22.5 restore
  function automatic logic [DW_OUT-1:0] sat(
    input logic signed [DW_IN-1:0] x
  );
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] y;
    p = PW'(x) * K45;
    y = p >>> 1;
    if (y > SMAX)
      sat = SMAX[DW_OUT-1:0];
    else if (y < SMIN)
      sat = SMIN[DW_OUT-1:0];
    else
      sat = y[DW_OUT-1:0];
  endfunction

  state_t        state;
  state_t        nstate;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] nidx;
  logic [AW-1:0] addr;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          acc;
  logic          wr_last;
  logic          rd_en;
  logic          sof_c;
  logic          rel;
  logic [MW-1:0] wdata;
  logic [MW-1:0] rd_q;
  logic          rd_vld_q;
  logic          rd_sof_q;
  logic [MW-1:0] mem [2*N_FFT];

  assign di_rdy  = ~full[wr_bank];
  assign acc     = di_vld & di_rdy;
  assign wr_last = acc & (wr_cnt == LAST);
  assign wdata   = {sat(di_re), sat(di_im)};

  always_ff @(posedge clk) begin
    if (acc)
      mem[{wr_bank, wr_cnt}] <= wdata;
  end

  // IDLE issues the first CP read itself to save a cycle of latency
  always_comb begin
    nstate = state;
    nidx   = rd_idx;
    addr   = rd_idx;
    rd_en  = 1'b0;
    sof_c  = 1'b0;
    rel    = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          rd_en  = 1'b1;
          addr   = CP0;
          sof_c  = 1'b1;
          nidx   = CP0 + AW'(1);
          nstate = (CP0 == LAST) ? BODY : CP;
        end
      end
      CP: begin
        rd_en = 1'b1;
        sof_c = (rd_idx == CP0);
        nidx  = rd_idx + AW'(1);
        if (rd_idx == LAST)
          nstate = BODY;
      end
      BODY: begin
        rd_en = 1'b1;
        nidx  = rd_idx + AW'(1);
        if (rd_idx == LAST) begin
          rel = 1'b1;
          if (full[~rd_bank]) begin
            nstate = CP;
            nidx   = CP0;
          end else begin
            nstate = IDLE;
          end
        end
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  always_comb begin
    full_n = full;
    if (wr_last)
      full_n[wr_bank] = 1'b1;
    if (rel)
      full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      rd_idx   <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= '0;
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
      rd_sof_q <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
      do_vld   <= 1'b0;
      do_sof   <= 1'b0;
    end else begin
      state <= nstate;
      rd_idx <= nidx;
      full <= full_n;
      if (acc)
        wr_cnt <= wr_cnt + AW'(1);
      if (wr_last)
        wr_bank <= ~wr_bank;
      if (rel)
        rd_bank <= ~rd_bank;
      if (rd_en)
        rd_q <= mem[{rd_bank, addr}];
      rd_vld_q <= rd_en;
      rd_sof_q <= sof_c;
      do_vld   <= rd_vld_q;
      do_sof   <= rd_vld_q & rd_sof_q;
      do_re    <= rd_vld_q ? rd_q[MW-1:DW_OUT] : '0;
      do_im    <= rd_vld_q ? rd_q[DW_OUT-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_sp_ifft_cp.sv
// Directed bench for sp_ifft_cp: scaling, CP ordering,
// latency, back-to-back streaming, stalls and mid-run reset.
module tb_sp_ifft_cp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic signed [15:0] di_re = '0;
  logic signed [15:0] di_im = '0;
  logic di_vld = 1'b0;
  logic di_rdy;
  logic signed [11:0] do_re;
  logic signed [11:0] do_im;
  logic do_vld;
  logic do_sof;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int rdy_cyc = 0;
  bit stall_seen = 0;
  int q_re[$];
  int q_im[$];
  int q_cyc[$];
  bit q_sof[$];

  sp_ifft_cp dut (
    .clk(clk),
    .rst_n(rst_n),
    .di_re(di_re),
    .di_im(di_im),
    .di_vld(di_vld),
    .di_rdy(di_rdy),
    .do_re(do_re),
    .do_im(do_im),
    .do_vld(do_vld),
    .do_sof(do_sof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (do_vld === 1'b1) begin
      q_re.push_back(int'(do_re));
      q_im.push_back(int'(do_im));
      q_sof.push_back(do_sof);
      q_cyc.push_back(cyc);
    end else begin
      checks++;
      if (do_re !== 0 || do_im !== 0 || do_sof !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero cyc=%0d re=%0d im=%0d sof=%b required 0",
                 cyc, do_re, do_im, do_sof);
      end
    end
  end

  function automatic int pat_re(int pat, int k);
    case (pat)
      0: return k;
      1, 2, 3: return k - 32 + pat;
      4: return 40 - k;
      5: return k / 2;
      6: return (k == 0) ? -77 : k;
      7: return (k == 0) ? 100 : (k == 1) ? 1 : (k == 2) ? 0 : 32767;
      default: return 0;
    endcase
  endfunction

  function automatic int pat_im(int pat, int k);
    case (pat)
      0: return -k;
      1, 2, 3: return pat * 10 - k;
      4: return k - 20;
      5: return -(k / 3);
      6: return (k == 0) ? 55 : k;
      7: return (k == 0) ? -100 : (k == 1) ? -1 : (k == 2) ? 0 : -32768;
      default: return 0;
    endcase
  endfunction

  function automatic int scl(int x);
    int p;
    int y;
    p = x * 45;
    if (p >= 0) y = p / 2;
    else y = -((-p + 1) / 2);
    if (y > 2047) y = 2047;
    if (y < -2048) y = -2048;
    return y;
  endfunction

  function automatic int sym_bad(int base, int pat);
    int bad;
    int idx;
    bad = 0;
    if (base + 80 > q_re.size()) return 999;
    for (int i = 0; i < 80; i++) begin
      idx = (i < 16) ? 48 + i : i - 16;
      if (q_re[base+i] != scl(pat_re(pat, idx))) bad++;
      if (q_im[base+i] != scl(pat_im(pat, idx))) bad++;
      if (q_sof[base+i] != (i == 0)) bad++;
    end
    return bad;
  endfunction

  function automatic int sof_cnt();
    int s;
    s = 0;
    foreach (q_sof[i]) s += int'(q_sof[i]);
    return s;
  endfunction

  task automatic clear_q();
    q_re.delete();
    q_im.delete();
    q_sof.delete();
    q_cyc.delete();
  endtask

  task automatic put(input int re, input int im);
    int n;
    di_re = 16'(re);
    di_im = 16'(im);
    di_vld = 1'b1;
    @(negedge clk);
    n = 0;
    while (di_rdy !== 1'b1 && n < 3000) begin
      stall_seen = 1;
      n++;
      @(negedge clk);
    end
    if (n > 0) rdy_cyc = cyc;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL put_timeout di_rdy=%b required 1", di_rdy);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic send_sym(input int pat, input bit gap);
    for (int k = 0; k < 64; k++) begin
      put(pat_re(pat, k), pat_im(pat, k));
      if (gap) begin
        di_vld = 1'b0;
        di_re = 16'h7abc;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (q_re.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (do_vld !== 1'b0 || do_sof !== 1'b0 || do_re !== 0 || do_im !== 0) begin
      errors++;
      $display("FAIL reset_out vld=%b sof=%b re=%0d im=%0d required 0",
               do_vld, do_sof, do_re, do_im);
    end
    checks++;
    if (di_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy di_rdy=%b required 1", di_rdy);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int acc;
    int nb;
    clear_q();
    send_sym(0, 0);
    di_vld = 1'b0;
    acc = last_acc;
    wait_out(80);
    checks++;
    if (q_re.size() !== 80) begin
      errors++;
      $display("FAIL single_count got=%0d required 80", q_re.size());
      return;
    end
    checks++;
    if (q_cyc[0] !== acc + 2) begin
      errors++;
      $display("FAIL single_latency got=%0d required %0d", q_cyc[0] - acc, 2);
    end
    checks++;
    if (q_re[0] !== 1080 || q_im[0] !== -1080) begin
      errors++;
      $display("FAIL single_k48 got=%0d,%0d required 1080,-1080",
               q_re[0], q_im[0]);
    end
    checks++;
    if (q_re[15] !== 1417 || q_im[15] !== -1418) begin
      errors++;
      $display("FAIL single_k63 got=%0d,%0d required 1417,-1418",
               q_re[15], q_im[15]);
    end
    nb = sym_bad(0, 0);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL single_order bad=%0d required 0", nb);
    end
    checks++;
    if (q_cyc[79] - q_cyc[0] !== 79) begin
      errors++;
      $display("FAIL single_contig span=%0d required 79", q_cyc[79] - q_cyc[0]);
    end
  endtask

  task automatic test_scaling();
    clear_q();
    send_sym(7, 0);
    di_vld = 1'b0;
    wait_out(80);
    checks++;
    if (q_re.size() !== 80) begin
      errors++;
      $display("FAIL scale_count got=%0d required 80", q_re.size());
      return;
    end
    checks++;
    if (q_re[16] !== 2047 || q_im[16] !== -2048) begin
      errors++;
      $display("FAIL scale_100 got=%0d,%0d required 2047,-2048",
               q_re[16], q_im[16]);
    end
    checks++;
    if (q_re[17] !== 22 || q_im[17] !== -23) begin
      errors++;
      $display("FAIL scale_1 got=%0d,%0d required 22,-23", q_re[17], q_im[17]);
    end
    checks++;
    if (q_re[18] !== 0 || q_im[18] !== 0) begin
      errors++;
      $display("FAIL scale_0 got=%0d,%0d required 0,0", q_re[18], q_im[18]);
    end
    checks++;
    if (q_re[0] !== 2047 || q_im[0] !== -2048) begin
      errors++;
      $display("FAIL scale_max got=%0d,%0d required 2047,-2048",
               q_re[0], q_im[0]);
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    clear_q();
    stall_seen = 0;
    send_sym(1, 0);
    send_sym(2, 0);
    send_sym(3, 0);
    di_vld = 1'b0;
    wait_out(240);
    checks++;
    if (q_re.size() !== 240) begin
      errors++;
      $display("FAIL b2b_count got=%0d required 240", q_re.size());
      return;
    end
    checks++;
    if (stall_seen !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rdy_drop got=%b required 1", stall_seen);
    end
    checks++;
    if (q_cyc[239] - q_cyc[0] !== 239) begin
      errors++;
      $display("FAIL b2b_contig span=%0d required 239", q_cyc[239] - q_cyc[0]);
    end
    checks++;
    if (sof_cnt() !== 3 || !q_sof[0] || !q_sof[80] || !q_sof[160]) begin
      errors++;
      $display("FAIL b2b_sof count=%0d required 3 at 0,80,160", sof_cnt());
    end
    nb = sym_bad(0, 1) + sym_bad(80, 2) + sym_bad(160, 3);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL b2b_data bad=%0d required 0", nb);
    end
  endtask

  task automatic test_gaps();
    int nb;
    clear_q();
    send_sym(0, 1);
    di_vld = 1'b0;
    wait_out(80);
    checks++;
    if (q_re.size() !== 80) begin
      errors++;
      $display("FAIL gap_count got=%0d required 80", q_re.size());
      return;
    end
    nb = sym_bad(0, 0);
    checks++;
    if (nb !== 0 || sof_cnt() !== 1) begin
      errors++;
      $display("FAIL gap_data bad=%0d sof=%0d required 0,1", nb, sof_cnt());
    end
    checks++;
    if (q_cyc[0] !== last_acc + 2) begin
      errors++;
      $display("FAIL gap_latency got=%0d required 2", q_cyc[0] - last_acc);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int nb;
    clear_q();
    send_sym(0, 0);
    for (int k = 0; k < 10; k++) put(pat_re(2, k), pat_im(2, k));
    di_vld = 1'b0;
    t = 0;
    while (q_re.size() < 30 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (do_vld !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_vld got=%b required 1", do_vld);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (do_vld !== 1'b0 || do_re !== 0 || do_im !== 0 || do_sof !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_out vld=%b re=%0d im=%0d required 0",
               do_vld, do_re, do_im);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (di_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rdy got=%b required 1", di_rdy);
    end
    clear_q();
    send_sym(1, 0);
    di_vld = 1'b0;
    wait_out(80);
    checks++;
    if (q_re.size() !== 80) begin
      errors++;
      $display("FAIL rst_mid_count got=%0d required 80", q_re.size());
      return;
    end
    nb = sym_bad(0, 1);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL rst_mid_data bad=%0d required 0", nb);
    end
  endtask

  task automatic test_stall();
    int nb;
    clear_q();
    stall_seen = 0;
    send_sym(4, 0);
    send_sym(5, 0);
    send_sym(6, 0);
    di_vld = 1'b0;
    wait_out(240);
    checks++;
    if (q_re.size() !== 240) begin
      errors++;
      $display("FAIL stall_count got=%0d required 240", q_re.size());
      return;
    end
    checks++;
    if (stall_seen !== 1'b1 || q_cyc[79] !== rdy_cyc + 1) begin
      errors++;
      $display("FAIL stall_release stall=%b rdy_cyc=%0d last0=%0d required %0d",
               stall_seen, rdy_cyc, q_cyc[79], rdy_cyc + 1);
    end
    checks++;
    if (q_re[176] !== -1733 || q_im[176] !== 1237) begin
      errors++;
      $display("FAIL stall_held got=%0d,%0d required -1733,1237",
               q_re[176], q_im[176]);
    end
    nb = sym_bad(0, 4) + sym_bad(80, 5) + sym_bad(160, 6);
    checks++;
    if (nb !== 0 || q_cyc[239] - q_cyc[0] !== 239) begin
      errors++;
      $display("FAIL stall_data bad=%0d span=%0d required 0,239",
               nb, q_cyc[239] - q_cyc[0]);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_scaling();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
